// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM bus arbiter: requester IDs and FIFO pointer sizing.
package ram_arb_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_id_e;

    // A single-entry FIFO still needs a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// In-order FIFO of requester IDs, one entry per downstream read still awaiting its data.
module resp_id_fifo
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_b,
    input  logic    push,
    input  logic    pop,
    input  arb_id_e din,
    output arb_id_e dout,
    output logic    full,
    output logic    empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    arb_id_e       slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = slots[rd_ptr];

    // NOTE: storage needs no reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM bus between instruction-fetch and load/store requesters.
// Define RAM_ARB_RR_EN for round-robin conflict resolution; otherwise DATA always wins.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst_b,

    input  logic            instr_req,
    input  logic            instr_write,
    input  logic [DW/8-1:0] instr_wstrb,
    input  logic [AW-1:0]   instr_addr,
    input  logic [DW-1:0]   instr_wdata,
    output logic            instr_addr_ok,
    output logic            instr_data_ok,
    output logic [DW-1:0]   instr_rdata,

    input  logic            data_req,
    input  logic            data_write,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [DW-1:0]   data_rdata,

    output logic            m_req,
    output logic            m_write,
    output logic [DW/8-1:0] m_wstrb,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_addr_ok,
    input  logic            m_data_ok,
    input  logic [DW-1:0]   m_rdata
);

    arb_id_e winner;
    arb_id_e head_id;
    logic    data_sel;
    logic    win_req;
    logic    blocked;
    logic    accept;
    logic    push;
    logic    pop;
    logic    fifo_full;
    logic    fifo_empty;

`ifdef RAM_ARB_RR_EN
    arb_id_e last_grant;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            last_grant <= ARB_INSTR;
        end else if (accept) begin
            last_grant <= winner;
        end
    end
`endif

    always_comb begin
        // NOTE: default assignment first so no path through this block leaves winner unassigned.
        winner = ARB_DATA;
        if (instr_req && data_req) begin
`ifdef RAM_ARB_RR_EN
            winner = (last_grant == ARB_DATA) ? ARB_INSTR : ARB_DATA;
`else
            winner = ARB_DATA;
`endif
        end else if (instr_req) begin
            winner = ARB_INSTR;
        end
    end

    assign data_sel  = (winner == ARB_DATA);
    assign win_req   = data_sel ? data_req   : instr_req;
    assign m_write   = data_sel ? data_write : instr_write;
    assign m_wstrb   = data_sel ? data_wstrb : instr_wstrb;
    assign m_addr    = data_sel ? data_addr  : instr_addr;
    assign m_wdata   = data_sel ? data_wdata : instr_wdata;

    // A full ID FIFO stalls reads even if a pop frees a slot this cycle; writes never need a slot.
    assign blocked   = fifo_full & ~m_write;
    assign m_req     = rst_b & win_req & ~blocked;
    assign accept    = m_req & m_addr_ok;
    assign push      = accept & ~m_write;

    assign instr_addr_ok = accept & ~data_sel;
    assign data_addr_ok  = accept &  data_sel;

    assign pop           = rst_b & m_data_ok & ~fifo_empty;
    assign instr_data_ok = pop & (head_id == ARB_INSTR);
    assign data_data_ok  = pop & (head_id == ARB_DATA);
    assign instr_rdata   = m_rdata;
    assign data_rdata    = m_rdata;

    resp_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push),
        .pop   (pop),
        .din   (winner),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifndef SYNTHESIS
    resp_has_owner: assert property (@(posedge clk) disable iff (!rst_b)
        !(m_data_ok && fifo_empty));
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 1-cycle RAM model whose responses can be stalled.
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          instr_req, instr_write;
    logic [3:0]    instr_wstrb;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_wdata;
    logic          instr_addr_ok, instr_data_ok;
    logic [DW-1:0] instr_rdata;
    logic          data_req, data_write;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          m_req, m_write;
    logic [3:0]    m_wstrb;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_addr_ok;
    logic          m_data_ok = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    logic [DW-1:0] ram [1 << AW];
    logic [DW-1:0] pend [$];
    logic          stall;
    logic [4:0]    hs;
    int            tests = 0;
    int            fails = 0;

    assign hs = {m_req, instr_addr_ok, data_addr_ok, instr_data_ok, data_data_ok};

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_OUTST(2)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .instr_req     (instr_req),
        .instr_write   (instr_write),
        .instr_wstrb   (instr_wstrb),
        .instr_addr    (instr_addr),
        .instr_wdata   (instr_wdata),
        .instr_addr_ok (instr_addr_ok),
        .instr_data_ok (instr_data_ok),
        .instr_rdata   (instr_rdata),
        .data_req      (data_req),
        .data_write    (data_write),
        .data_wstrb    (data_wstrb),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .m_req         (m_req),
        .m_write       (m_write),
        .m_wstrb       (m_wstrb),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_addr_ok     (m_addr_ok),
        .m_data_ok     (m_data_ok),
        .m_rdata       (m_rdata)
    );

    // RAM model: reads accepted at an edge return in order from the next cycle unless stalled.
    always @(posedge clk) begin
        if (m_data_ok) void'(pend.pop_front());
        if (m_req && m_addr_ok) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) ram[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
                pend.push_back(ram[m_addr]);
            end
        end
        if (pend.size() != 0 && !stall) begin
            m_data_ok <= 1'b1;
            m_rdata   <= pend[0];
        end else begin
            m_data_ok <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000 time units");
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [11:0] a);
        return 32'hC000_0000 | {20'h0, a};
    endfunction

    function automatic logic data_wins(input int i);
`ifdef RAM_ARB_RR_EN
        return (i % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic req, input logic wr, input logic [11:0] a,
                               input logic [3:0] s, input logic [31:0] d);
        instr_req = req; instr_write = wr; instr_addr = a; instr_wstrb = s; instr_wdata = d;
    endtask

    task automatic drive_data(input logic req, input logic wr, input logic [11:0] a,
                              input logic [3:0] s, input logic [31:0] d);
        data_req = req; data_write = wr; data_addr = a; data_wstrb = s; data_wdata = d;
    endtask

    task automatic idle();
        drive_instr(1'b0, 1'b0, '0, '0, '0);
        drive_data(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        drive_instr(1'b1, 1'b0, 12'h010, 4'h0, '0);
        drive_data(1'b1, 1'b1, 12'h020, 4'hF, 32'h1);
        @(negedge clk);
        tests++;
        if (hs !== 5'b00000) begin
            fails++; $display("FAIL reset_outputs: got %b, required %b", hs, 5'b00000);
        end
        next_cycle();
        rst_b = 1'b1;
        idle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b00000) begin
            fails++; $display("FAIL reset_idle: got %b, required %b", hs, 5'b00000);
        end
        next_cycle();
    endtask

    task automatic test_instr_read();
        m_addr_ok = 1'b0;
        drive_instr(1'b1, 1'b0, 12'h010, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b10000) begin
            fails++; $display("FAIL ir_not_ready: got %b, required %b", hs, 5'b10000);
        end
        next_cycle();
        m_addr_ok = 1'b1;
        @(negedge clk);
        tests++;
        if (hs !== 5'b11000) begin
            fails++; $display("FAIL ir_accept: got %b, required %b", hs, 5'b11000);
        end
        tests++;
        if (m_addr !== 12'h010) begin
            fails++; $display("FAIL ir_addr: got %h, required %h", m_addr, 12'h010);
        end
        next_cycle();
        idle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b00010) begin
            fails++; $display("FAIL ir_resp: got %b, required %b", hs, 5'b00010);
        end
        tests++;
        if (instr_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL ir_rdata: got %h, required %h", instr_rdata, 32'hDEADBEEF);
        end
        next_cycle();
    endtask

    task automatic test_conflict();
        drive_instr(1'b1, 1'b0, 12'h004, 4'h0, '0);
        drive_data(1'b1, 1'b0, 12'h008, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b10100 || m_addr !== 12'h008) begin
            fails++; $display("FAIL cf_data_first: got %b/%h, required %b/%h", hs, m_addr, 5'b10100, 12'h008);
        end
        next_cycle();
        drive_data(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b11001 || m_addr !== 12'h004) begin
            fails++; $display("FAIL cf_instr_next: got %b/%h, required %b/%h", hs, m_addr, 5'b11001, 12'h004);
        end
        tests++;
        if (data_rdata !== word(12'h008)) begin
            fails++; $display("FAIL cf_data_rdata: got %h, required %h", data_rdata, word(12'h008));
        end
        next_cycle();
        idle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b00010 || instr_rdata !== word(12'h004)) begin
            fails++; $display("FAIL cf_instr_resp: got %b/%h, required %b/%h", hs, instr_rdata, 5'b00010, word(12'h004));
        end
        next_cycle();
    endtask

    task automatic test_write_merge();
        drive_data(1'b1, 1'b1, 12'h020, 4'b0011, 32'h12345678);
        @(negedge clk);
        tests++;
        if (hs !== 5'b10100 || {m_write, m_wstrb} !== 5'b10011 || m_wdata !== 32'h12345678) begin
            fails++; $display("FAIL wr_accept: got %b/%b/%h, required %b/%b/%h",
                              hs, {m_write, m_wstrb}, m_wdata, 5'b10100, 5'b10011, 32'h12345678);
        end
        next_cycle();
        drive_data(1'b1, 1'b0, 12'h020, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b10100) begin
            fails++; $display("FAIL wr_no_data_ok: got %b, required %b", hs, 5'b10100);
        end
        next_cycle();
        idle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b00001 || data_rdata !== 32'hAAAA5678) begin
            fails++; $display("FAIL wr_readback: got %b/%h, required %b/%h", hs, data_rdata, 5'b00001, 32'hAAAA5678);
        end
        next_cycle();
    endtask

    task automatic test_full_stall();
        stall = 1'b1;
        drive_data(1'b1, 1'b0, 12'h030, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b10100) begin
            fails++; $display("FAIL st_read0: got %b, required %b", hs, 5'b10100);
        end
        next_cycle();
        drive_data(1'b1, 1'b0, 12'h031, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b10100) begin
            fails++; $display("FAIL st_read1: got %b, required %b", hs, 5'b10100);
        end
        next_cycle();
        drive_data(1'b1, 1'b0, 12'h032, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b00000) begin
            fails++; $display("FAIL st_blocked: got %b, required %b", hs, 5'b00000);
        end
        next_cycle();
        drive_data(1'b0, 1'b0, '0, '0, '0);
        drive_instr(1'b1, 1'b1, 12'h033, 4'hF, 32'h5555_0000);
        stall = 1'b0;
        @(negedge clk);
        tests++;
        if (hs !== 5'b11000) begin
            fails++; $display("FAIL st_write_when_full: got %b, required %b", hs, 5'b11000);
        end
        next_cycle();
        drive_instr(1'b0, 1'b0, '0, '0, '0);
        drive_data(1'b1, 1'b0, 12'h032, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b00001 || data_rdata !== word(12'h030)) begin
            fails++; $display("FAIL st_pop_no_bypass: got %b/%h, required %b/%h", hs, data_rdata, 5'b00001, word(12'h030));
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b10101 || data_rdata !== word(12'h031)) begin
            fails++; $display("FAIL st_read2_accept: got %b/%h, required %b/%h", hs, data_rdata, 5'b10101, word(12'h031));
        end
        next_cycle();
        idle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b00001 || data_rdata !== word(12'h032)) begin
            fails++; $display("FAIL st_read2_resp: got %b/%h, required %b/%h", hs, data_rdata, 5'b00001, word(12'h032));
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b00000) begin
            fails++; $display("FAIL st_drained: got %b, required %b", hs, 5'b00000);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic        prev_valid = 1'b0;
        logic        prev_d = 1'b0;
        logic [31:0] prev_w = '0;
        logic        d;
        rst_b = 1'b0;
        idle();
        next_cycle();
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_instr(1'b1, 1'b0, 12'h040 + 12'(i), 4'h0, '0);
            drive_data(1'b1, 1'b0, 12'h080 + 12'(i), 4'h0, '0);
            d = data_wins(i);
            @(negedge clk);
            tests++;
            if (hs !== {1'b1, ~d, d, prev_valid & ~prev_d, prev_valid & prev_d}) begin
                fails++; $display("FAIL b2b_grant[%0d]: got %b, required %b", i, hs,
                                  {1'b1, ~d, d, prev_valid & ~prev_d, prev_valid & prev_d});
            end
            if (prev_valid) begin
                tests++;
                if (data_rdata !== prev_w) begin
                    fails++; $display("FAIL b2b_rdata[%0d]: got %h, required %h", i, data_rdata, prev_w);
                end
            end
            prev_valid = 1'b1;
            prev_d     = d;
            prev_w     = word(d ? 12'h080 + 12'(i) : 12'h040 + 12'(i));
            next_cycle();
        end
        idle();
        @(negedge clk);
        tests++;
        if (hs !== {3'b000, ~prev_d, prev_d} || data_rdata !== prev_w) begin
            fails++; $display("FAIL b2b_last: got %b/%h, required %b/%h", hs, data_rdata, {3'b000, ~prev_d, prev_d}, prev_w);
        end
        next_cycle();
    endtask

    task automatic test_reset_inflight();
        drive_data(1'b1, 1'b0, 12'h050, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b10100) begin
            fails++; $display("FAIL rst_read_accept: got %b, required %b", hs, 5'b10100);
        end
        next_cycle();
        rst_b = 1'b0;
        drive_data(1'b0, 1'b0, '0, '0, '0);
        drive_instr(1'b1, 1'b0, 12'h051, 4'h0, '0);
        @(negedge clk);
        tests++;
        if (hs !== 5'b00000) begin
            fails++; $display("FAIL rst_late_resp: got %b, required %b", hs, 5'b00000);
        end
        next_cycle();
        rst_b = 1'b1;
        @(negedge clk);
        tests++;
        if (hs !== 5'b11000) begin
            fails++; $display("FAIL rst_new_read: got %b, required %b", hs, 5'b11000);
        end
        next_cycle();
        idle();
        @(negedge clk);
        tests++;
        if (hs !== 5'b00010 || instr_rdata !== word(12'h051)) begin
            fails++; $display("FAIL rst_new_resp: got %b/%h, required %b/%h", hs, instr_rdata, 5'b00010, word(12'h051));
        end
        next_cycle();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) ram[a] = word(12'(a));
        ram[12'h010] = 32'hDEADBEEF;
        ram[12'h020] = 32'hAAAAAAAA;
        stall     = 1'b0;
        m_addr_ok = 1'b1;
        rst_b     = 1'b0;
        idle();
        test_reset();
        test_instr_read();
        test_conflict();
        test_write_merge();
        test_full_stall();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
